// File: rtl/fifo_stream_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_stream_out
// Purpose  : Drains a 1-cycle-latency FIFO read port into an AXI4-Stream
//            master. Asserts TLAST on every PACKET_LEN-th beat. A 2-entry
//            skid buffer hides the read latency and absorbs backpressure.
// Options  : FIFO_STREAM_OUT_STATS_EN - when defined, PKT_COUNT counts
//            completed packets; otherwise PKT_COUNT is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_out #(
  parameter int FIFO_WIDTH = 32,
  parameter int PACKET_LEN = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EN,
  output logic                  RD_CMD,
  input  logic [FIFO_WIDTH-1:0] RD_DATA,
  input  logic                  FIFO_EMPTY,
  output logic [FIFO_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  BUSY,
  output logic [31:0]           PKT_COUNT
);

  localparam logic [15:0] C_LAST_IDX = 16'(PACKET_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [FIFO_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q;
  logic [15:0]           iss_cnt_q, iss_cnt_d;
  logic [15:0]           out_cnt_q, out_cnt_d;

  logic                  w_issue_ok;
  logic                  w_pop;
  logic                  w_wr_en;
  logic                  w_room;

  // Stream handshake and read issue; the room test is occ + infl - pop < 2
  // rearranged to avoid a negative intermediate.
  assign M_AXIS_TVALID = (occ_q != 2'd0);
  assign M_AXIS_TDATA  = buf_q[rd_ptr_q];
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (out_cnt_q == C_LAST_IDX);
  assign w_pop         = M_AXIS_TVALID && M_AXIS_TREADY;
  assign w_wr_en       = infl_q;
  assign w_room        = (({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, w_pop}));
  assign RD_CMD        = w_issue_ok && !FIFO_EMPTY && w_room;
  assign BUSY          = (state_q != S_IDLE) || (occ_q != 2'd0) || infl_q;

  // Occupancy after this cycle's buffer write and stream pop.
  always_comb begin
    occ_d = occ_q;
    case ({w_wr_en, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Per-packet read and beat counters, both wrapping at the packet boundary.
  always_comb begin
    iss_cnt_d = iss_cnt_q;
    out_cnt_d = out_cnt_q;
    if (RD_CMD) begin
      iss_cnt_d = (iss_cnt_q == C_LAST_IDX) ? 16'd0 : iss_cnt_q + 16'd1;
    end
    if (w_pop) begin
      out_cnt_d = M_AXIS_TLAST ? 16'd0 : out_cnt_q + 16'd1;
    end
  end

  // Read permission per state; kept apart from next-state so RD_CMD has no
  // path back into itself.
  always_comb begin
    w_issue_ok = 1'b0;
    case (state_q)
      S_ACTIVE: w_issue_ok = 1'b1;
      S_FINISH: w_issue_ok = (iss_cnt_q != 16'd0);
      default:  w_issue_ok = 1'b0;
    endcase
  end

  // Next state. Leaving ACTIVE looks at the post-issue count so a read issued
  // in the same cycle as the EN drop is still completed to a full packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (EN) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!EN) state_d = (iss_cnt_d == 16'd0) ? S_IDLE : S_FINISH;
      end
      S_FINISH: begin
        if (EN) begin
          state_d = S_ACTIVE;
        end else if ((iss_cnt_q == 16'd0) && (occ_q == 2'd0) && !infl_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the 2-entry output buffer.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
      infl_q    <= 1'b0;
      iss_cnt_q <= 16'd0;
      out_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      if (w_wr_en) buf_q[wr_ptr_q] <= RD_DATA;
      wr_ptr_q  <= wr_ptr_q ^ w_wr_en;
      rd_ptr_q  <= rd_ptr_q ^ w_pop;
      occ_q     <= occ_d;
      infl_q    <= RD_CMD;
      iss_cnt_q <= iss_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef FIFO_STREAM_OUT_STATS_EN
  logic [31:0] pkt_cnt_q;

  // Completed-packet counter, wraps naturally at 2^32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pkt_cnt_q <= 32'd0;
    end else if (w_pop && M_AXIS_TLAST) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign PKT_COUNT = pkt_cnt_q;
`else
  assign PKT_COUNT = 32'd0;
`endif

  // A read landing in a full buffer with no pop would lose data.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !((occ_q == 2'd2) && infl_q && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_out
// Purpose  : Self-checking bench for fifo_stream_out with a FIFO read-port
//            model and a scoreboard of words handed to the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_out;

  localparam int W  = 32;
  localparam int PL = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          EN;
  logic          RD_CMD;
  logic [W-1:0]  RD_DATA;
  logic          FIFO_EMPTY;
  logic [W-1:0]  TDATA;
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
  logic          BUSY;
  logic [31:0]   PKT_COUNT;

  fifo_stream_out #(.FIFO_WIDTH(W), .PACKET_LEN(PL)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .RD_CMD(RD_CMD), .RD_DATA(RD_DATA),
    .FIFO_EMPTY(FIFO_EMPTY), .M_AXIS_TDATA(TDATA), .M_AXIS_TVALID(TVALID),
    .M_AXIS_TREADY(TREADY), .M_AXIS_TLAST(TLAST), .BUSY(BUSY),
    .PKT_COUNT(PKT_COUNT)
  );

  always #5 CLK = ~CLK;

  // Upstream FIFO model: array written by stimulus, read pointer advanced
  // here; read data is valid the cycle after an accepted pop.
  logic [W-1:0] fmem [0:1023];
  int           wr_idx = 0;
  int           rd_idx = 0;
  assign FIFO_EMPTY = (rd_idx == wr_idx);

  always @(posedge CLK) begin
    if (RD_CMD && !FIFO_EMPTY) begin
      RD_DATA <= fmem[rd_idx];
      rd_idx  <= rd_idx + 1;
    end else begin
      RD_DATA <= $urandom;
    end
  end

  logic [W-1:0] sb [$];
  int checks = 0, errors = 0;
  int m_occ = 0, m_infl = 0, beat_in_pkt = 0;
  int beats_total = 0, lasts_total = 0, reads_total = 0, exp_pkts = 0;
  logic         stalled_prev = 1'b0, prev_last = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_idx] = $urandom;
      wr_idx++;
    end
  endtask

  // Cycle monitor, called at the falling edge with inputs already stable.
  task automatic monitor();
    int p;
    logic acc;
    logic [W-1:0] e;
    if (RESET) begin
      chk("rst_tvalid", TVALID, 0);
      chk("rst_rd_cmd", RD_CMD, 0);
      chk("rst_tlast", TLAST, 0);
      chk("rst_tdata", TDATA, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_pkt_count", PKT_COUNT, 0);
      m_occ = 0; m_infl = 0; beat_in_pkt = 0; exp_pkts = 0;
      stalled_prev = 1'b0;
      sb.delete();
      return;
    end
    p = (TVALID && TREADY) ? 1 : 0;
    chk("tvalid", TVALID, m_occ > 0);
    chk("tlast", TLAST, (m_occ > 0) && (beat_in_pkt == PL - 1));
    if (RD_CMD) begin
      chk("rd_while_empty", FIFO_EMPTY, 0);
      chk("rd_level_ok", (m_occ + m_infl - p) < 2, 1);
    end
    if (stalled_prev) begin
      chk("tdata_stable", TDATA, prev_data);
      chk("tlast_stable", TLAST, prev_last);
    end
    if (p == 1) begin
      if (sb.size() == 0) begin
        chk("beat_without_read", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("tdata_order", TDATA, e);
      end
      beats_total++;
      if (beat_in_pkt == PL - 1) begin
        beat_in_pkt = 0;
        lasts_total++;
        exp_pkts++;
      end else begin
        beat_in_pkt++;
      end
    end
`ifdef FIFO_STREAM_OUT_STATS_EN
    chk("pkt_count", PKT_COUNT, 64'(exp_pkts));
`else
    chk("pkt_count", PKT_COUNT, 0);
`endif
    acc = RD_CMD && !FIFO_EMPTY;
    if (acc) begin
      sb.push_back(fmem[rd_idx]);
      reads_total++;
    end
    m_occ  = m_occ + m_infl - p;
    m_infl = acc ? 1 : 0;
    stalled_prev = TVALID && !TREADY;
    prev_data    = TDATA;
    prev_last    = TLAST;
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  // Run with TREADY at the given duty until the beat total reaches target.
  task automatic run_until(input int target, input int budget, input int pct, output int cyc);
    cyc = 0;
    while (beats_total < target && cyc < budget) begin
      TREADY = ($urandom_range(99) < pct);
      tick();
      cyc++;
    end
    if (beats_total < target) chk("beat_timeout", beats_total, target);
    TREADY = 1'b1;
  endtask

  typedef struct {
    int add_words;
    int ready_pct;
    int exp_beats;
    int exp_lasts;
  } row_t;

  row_t rows [4];

  initial begin
    int b0, l0, r0, r1, cyc;
    // First row also drains the 5 words left over from the idle check.
    rows[0] = '{add_words: 11,  ready_pct: 100, exp_beats: 16,  exp_lasts: 2};
    rows[1] = '{add_words: 16,  ready_pct: 100, exp_beats: 16,  exp_lasts: 2};
    rows[2] = '{add_words: 200, ready_pct: 50,  exp_beats: 200, exp_lasts: 25};
    rows[3] = '{add_words: 24,  ready_pct: 30,  exp_beats: 24,  exp_lasts: 3};

    RESET = 1'b1; EN = 1'b0; TREADY = 1'b1;
    push_words(5);
    tick(); tick();
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_rd_cmd", RD_CMD, 0);
    end
    chk("idle_busy", BUSY, 0);
    chk("idle_reads", reads_total, 0);

    for (int r = 0; r < 4; r++) begin
      b0 = beats_total; l0 = lasts_total;
      push_words(rows[r].add_words);
      EN = 1'b1;
      run_until(b0 + rows[r].exp_beats, 20 * rows[r].exp_beats + 50, rows[r].ready_pct, cyc);
      if (rows[r].ready_pct == 100) chk("full_rate_cycles", cyc, rows[r].exp_beats + 3);
      EN = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("row_beats", beats_total - b0, rows[r].exp_beats);
      chk("row_lasts", lasts_total - l0, rows[r].exp_lasts);
      chk("row_busy_end", BUSY, 0);
    end

    // FIFO runs dry mid-packet, then refills.
    b0 = beats_total; l0 = lasts_total;
    push_words(5);
    EN = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("underflow_beats", beats_total - b0, 5);
    chk("underflow_no_last", lasts_total - l0, 0);
    chk("underflow_busy", BUSY, 1);
    push_words(3);
    run_until(b0 + 8, 50, 100, cyc);
    chk("underflow_lasts", lasts_total - l0, 1);
    EN = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("underflow_busy_end", BUSY, 0);

    // EN dropped after beat 3: the packet is completed, then nothing more.
    b0 = beats_total; l0 = lasts_total; r0 = reads_total;
    push_words(12);
    EN = 1'b1;
    run_until(b0 + 3, 40, 100, cyc);
    EN = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("endrop_reads", reads_total - r0, 8);
    chk("endrop_beats", beats_total - b0, 8);
    chk("endrop_lasts", lasts_total - l0, 1);
    chk("endrop_busy", BUSY, 0);
    r1 = reads_total;
    for (int i = 0; i < 20; i++) tick();
    chk("endrop_no_more_reads", reads_total, r1);
    chk("endrop_fifo_left", FIFO_EMPTY, 0);

    // Reset while beat 2 is stalled with the buffer full.
    b0 = beats_total;
    push_words(4);
    EN = 1'b1;
    run_until(b0 + 1, 40, 100, cyc);
    TREADY = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("prereset_tvalid", TVALID, 1);
    chk("prereset_model_occ", m_occ, 2);
    RESET = 1'b1;
    #1;
    chk("async_reset_tvalid", TVALID, 0);
    tick(); tick();
    RESET = 1'b0;
    TREADY = 1'b1;
    push_words(12);
    b0 = beats_total; l0 = lasts_total;
    run_until(b0 + 8, 60, 100, cyc);
    chk("postreset_lasts", lasts_total - l0, 1);
    EN = 1'b0;
    cyc = 0;
    while (BUSY && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("postreset_idle", BUSY, 0);
    chk("postreset_total_lasts", lasts_total - l0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
